data_block_memory: RTL and testbench



---
 rtl/data_block_memory.sv | 88 ++++++++
 tb/tb_data_block_memory.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_block_memory.sv
// Block-granular data memory answering the data cache's refill/write-back requests with a fixed latency.
// Optional macro DMEM_CLEAR_ON_RESET_EN: asynchronous clear of every array entry while RESET is low.
module data_block_memory #(
    parameter int ADDR_W     = 28,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic [ADDR_W-1:0] MEM_BLOCK_ADDR,
    input  logic [127:0]      MEM_WRITE_DATA,
    output logic              MEM_BUSYWAIT,
    output logic [127:0]      MEM_READ_DATA
);

    localparam int          CNT_W = $clog2(LATENCY) + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  op_write;
    logic [DEPTH_LOG2-1:0] idx;
    logic [127:0]          wdata;
    logic [127:0]          mem [DEPTH];
    logic                  commit;
    logic                  addr_unused_hi;

    // Upper block-address bits alias onto the same entries.
    assign addr_unused_hi = ^MEM_BLOCK_ADDR[ADDR_W-1:DEPTH_LOG2];

    assign commit = (state == ACCESS) && (cnt == '0);

    // Raised in the same cycle a request appears so the requester never sees a false completion.
    assign MEM_BUSYWAIT = RESET &&
                          ((state == ACCESS) || ((state == IDLE) && (MEM_READ || MEM_WRITE)));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            op_write      <= 1'b0;
            idx           <= '0;
            wdata         <= '0;
            MEM_READ_DATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_READ || MEM_WRITE) begin
                        op_write <= MEM_WRITE;
                        idx      <= MEM_BLOCK_ADDR[DEPTH_LOG2-1:0];
                        wdata    <= MEM_WRITE_DATA;
                        cnt      <= CNT_W'(LATENCY - 1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!op_write) MEM_READ_DATA <= mem[idx];
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_CLEAR_ON_RESET_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && op_write) begin
            mem[idx] <= wdata;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (commit && op_write) mem[idx] <= wdata;
    end
`endif

endmodule

// File: tb/tb_data_block_memory.sv
// Bench for data_block_memory: directed scenarios plus random traffic against a block-level reference model.
module tb_data_block_memory;

    localparam int LAT = 5;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_BLOCK_ADDR;
    logic [127:0] MEM_WRITE_DATA;
    logic         MEM_BUSYWAIT;
    logic [127:0] MEM_READ_DATA;

    int tests = 0;
    int fails = 0;

    logic [127:0] model_mem [int];
    logic [127:0] model_rd;

    data_block_memory #(.ADDR_W(28), .DEPTH_LOG2(8), .LATENCY(LAT)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_BLOCK_ADDR (MEM_BLOCK_ADDR),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_BUSYWAIT   (MEM_BUSYWAIT),
        .MEM_READ_DATA  (MEM_READ_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts edges until busywait drops; a stuck busywait ends after a bounded budget.
    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (MEM_BUSYWAIT === 1'b1 && n < 40);
        chk(tag, 128'(n), 128'(LAT + 1));
    endtask

    task automatic model_update(input bit wr, input logic [27:0] a, input logic [127:0] d);
        if (wr) model_mem[int'(a[7:0])] = d;
        else    model_rd = model_mem[int'(a[7:0])];
    endtask

    task automatic access(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                          input bit hold);
        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; MEM_BLOCK_ADDR = a; MEM_WRITE_DATA = d;
        #1;
        chk("busy_same_cycle", 128'(MEM_BUSYWAIT), 128'(1));
        run_to_done("latency");
        model_update(wr, a, d);
        chk("read_data", MEM_READ_DATA, model_rd);
        if (hold) begin
            // Request left high through DONE: the next edge returns to IDLE and busywait rises again.
            @(posedge CLK); #1;
            chk("busy_one_gap", 128'(MEM_BUSYWAIT), 128'(1));
            run_to_done("latency_second");
            model_update(wr, a, d);
            chk("read_data_second", MEM_READ_DATA, model_rd);
        end
        @(negedge CLK);
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        chk("busy_done", 128'(MEM_BUSYWAIT), 128'(0));
        @(posedge CLK); #1;
        chk("busy_idle", 128'(MEM_BUSYWAIT), 128'(0));
    endtask

    initial begin
        logic [127:0] blk_a;
        logic [127:0] blk_b;
        int           pool [6];
        int           sel;
        logic [27:0]  ra;
        logic [127:0] rd_data;

        pool = '{'h12, 5, 7, 'h33, 'h80, 'hff};
        blk_a = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        blk_b = 128'h11112222_33334444_55556666_77778888;
        model_rd = '0;
        RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        MEM_BLOCK_ADDR = '0; MEM_WRITE_DATA = '0;

        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("reset_busy", 128'(MEM_BUSYWAIT), 128'(0));
            chk("reset_rdata", MEM_READ_DATA, 128'(0));
        end

        access(1'b0, 1'b1, 28'h0000012, blk_a, 1'b0);
        access(1'b1, 1'b0, 28'h0000012, '0, 1'b0);
        chk("readback", MEM_READ_DATA, blk_a);

        access(1'b0, 1'b1, 28'h0000112, blk_b, 1'b0);
        access(1'b1, 1'b0, 28'h0000012, '0, 1'b0);
        chk("alias_readback", MEM_READ_DATA, blk_b);

        access(1'b1, 1'b1, 28'h0000005, '1, 1'b0);
        chk("both_high_rdata_kept", MEM_READ_DATA, blk_b);
        access(1'b1, 1'b0, 28'h0000005, '0, 1'b0);
        chk("both_high_written", MEM_READ_DATA, '1);

        access(1'b0, 1'b1, 28'h0000007, blk_a ^ blk_b, 1'b0);
        @(negedge CLK);
        MEM_WRITE = 1'b1; MEM_BLOCK_ADDR = 28'h0000007; MEM_WRITE_DATA = 128'h5A5A;
        @(posedge CLK); @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("abort_busy", 128'(MEM_BUSYWAIT), 128'(0));
        chk("abort_rdata", MEM_READ_DATA, 128'(0));
        model_rd = '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
`endif
        @(negedge CLK);
        MEM_WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        access(1'b1, 1'b0, 28'h0000007, '0, 1'b0);
        access(1'b1, 1'b0, 28'h0000012, '0, 1'b0);

        access(1'b0, 1'b1, 28'h0000033, 128'hC0FFEE, 1'b1);
        access(1'b1, 1'b0, 28'h0000033, '0, 1'b1);
        chk("held_read", MEM_READ_DATA, 128'hC0FFEE);

        for (int k = 0; k < 24; k++) begin
            sel = pool[$urandom_range(5, 0)];
            ra  = {20'($urandom), 8'(sel)};
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            if (model_mem.exists(sel) && ($urandom % 2 == 0))
                access(1'b1, 1'b0, ra, rd_data, 1'b0);
            else
                access(($urandom % 4) == 0, 1'b1, ra, rd_data, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
